servo_pwm_decoder: RTL and testbench
====================================

# servo_pwm_decoder

Measures an incoming 50 Hz servo PWM signal and reports its high-pulse width, its period, and the commanded servo position quantised to 10° steps (index 0–18). It is the receive-side counterpart of the servo PWM generator. Typical uses are reading an RC-receiver channel or checking the generator output in loopback. It runs on the 50 MHz system clock with no external debouncer.

## Interface
Parameters:
- MIN_PULSE, 50_000: cycles for 1 ms (0°)
- MAX_PULSE, 100_000: cycles for 2 ms (180°)
- STEP, 2_778: cycles per 10° step
- MAX_PERIOD, 1_200_000: timeout limit in cycles (24 ms)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-high
- pwm_in  in  1  raw servo PWM input, asynchronous to clk
- width  out  32  last measured high time in cycles, raw (not clamped)
- period  out  32  last measured rising-to-rising interval in cycles
- angle_idx  out  5  position index 0..18 (×10°)
- valid  out  1  one-cycle strobe when width/angle_idx update
- out_of_range  out  1  last width was < MIN_PULSE or > MAX_PULSE
- no_signal  out  1  timeout or no pulse since reset

## Operation
- Input path: 2-FF synchroniser gives `pwm_s`. Edges are detected by comparing `pwm_s` with its previous value.
- FSM states are IDLE, HIGH, CALC and LOW.
  - **IDLE:** waits for a rising edge. A level that is already high at reset is ignored until it falls and rises again.
  - **Rising edge in IDLE:** go to HIGH, `hi_cnt` = 1, `per_cnt` = 1.
  - **HIGH:** `hi_cnt` and `per_cnt` increment each cycle.
  - **Falling edge in HIGH:** latch `hi_cnt` into the internal width register, go to CALC.
  - **CALC:** `per_cnt` keeps counting. On the first CALC cycle:
    - `c` = clamp(width, MIN_PULSE, MAX_PULSE)
    - `rem` = `c` − MIN_PULSE + STEP/2 (rounds to nearest)
    - `idx` = 0
  - **CALC, each following cycle:** if `rem` ≥ STEP, then `rem` −= STEP and `idx`++. Otherwise:
    - register `width`, `angle_idx`, `out_of_range`
    - pulse `valid`
    - clear `no_signal`
    - go to LOW
  - **LOW:** `per_cnt` increments.
  - **Rising edge in LOW:** `period` ← `per_cnt`, then `hi_cnt` = 1, `per_cnt` = 1, go to HIGH.
- `angle_idx` never exceeds 18. Pulses above MAX_PULSE give 18 with `out_of_range` = 1. Pulses below MIN_PULSE give 0 with `out_of_range` = 1.
- Timeout: if `hi_cnt` or `per_cnt` reaches MAX_PERIOD in HIGH, CALC or LOW:
  - `no_signal` ← 1, go to IDLE
  - `width`, `period` and `angle_idx` hold their last values
  - no `valid`
- Rising edge during CALC (pulse train too fast) aborts the calculation:
  - no `valid`, outputs unchanged
  - `out_of_range` ← 1
  - `period` is not updated; go to HIGH with counters = 1
- `period` stays 0 until the first complete rising-to-rising interval after reset. After any timeout, it updates only on the second rising edge following IDLE.
- Counters cannot overflow, because MAX_PERIOD < 2^32 and the timeout fires first.

## Timing
- Reset values: `width` = 0, `period` = 0, `angle_idx` = 0, `valid` = 0, `out_of_range` = 0, `no_signal` = 1. The FSM starts in IDLE with counters at 0.
- Pin to `pwm_s` latency is 2 cycles (5 with PWM_DEGLITCH_EN).
- A measured width of N cycles reports exactly N when the high time on `pwm_in` is N cycles, since the sync delay is equal on both edges.
- Falling edge detected at cycle F: CALC holds cycles F+1 … F+1+k, with k = final `angle_idx` (at most 18 subtract cycles). `valid` is high for one cycle at F+2+k, with outputs already stable in that cycle.
- `period` updates in the cycle after the rising edge is detected. It does not pulse `valid`.
- Reset asserted mid-measurement returns all outputs to their reset values immediately and discards any partial count.

## Configuration
- `PWM_DEGLITCH_EN` defined: a 3-bit shift register follows the synchroniser. The filtered level changes only when all 3 samples agree, so glitches of 1–2 cycles are removed. This adds 3 cycles of latency on both edges.
- Not defined: 2-FF synchroniser only. Every level change on `pwm_s` is treated as an edge.

## Test plan
- 75_000-cycle high pulse, 1_000_000-cycle period, repeated 3 times: `width` = 75_000, `angle_idx` = 9, `valid` once per pulse. `period` = 1_000_000 from the second rising edge on. `no_signal` 1→0 after the first `valid`.
- Pulses of 50_000 / 100_000 / 52_778: `angle_idx` = 0 / 18 / 1, `out_of_range` = 0. The `valid` delay after the falling edge is 2 / 20 / 3 cycles.
- Pulses of 40_000 and 120_000: `angle_idx` = 0 and 18, `width` raw, `out_of_range` = 1.
- Input stuck high for 1_300_000 cycles: `no_signal` = 1 at `hi_cnt` = 1_200_000, no `valid`, FSM in IDLE. The next full pulse is measured normally.
- `rst` asserted during the HIGH phase of a pulse: all outputs go to reset values. The remaining partial pulse produces no `valid`.
- With PWM_DEGLITCH_EN, a 2-cycle low glitch inside a 75_000-cycle pulse still gives `width` = 75_000. Without the macro, the same input gives two short widths and `out_of_range` = 1.

Source files
------------

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures high width and period and quantises the pulse into a 0..18 angle index.
// Optional input glitch filter is enabled by defining PWM_DEGLITCH_EN.
module servo_pwm_decoder #(
    parameter int unsigned MIN_PULSE  = 50_000,
    parameter int unsigned MAX_PULSE  = 100_000,
    parameter int unsigned STEP       = 2_778,
    parameter int unsigned MAX_PERIOD = 1_200_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [31:0] width,
    output logic [31:0] period,
    output logic [4:0]  angle_idx,
    output logic        valid,
    output logic        out_of_range,
    output logic        no_signal
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHigh = 2'd1;
    localparam logic [1:0] StCalc = 2'd2;
    localparam logic [1:0] StLow  = 2'd3;

    localparam logic [31:0] MinPulse  = 32'(MIN_PULSE);
    localparam logic [31:0] MaxPulse  = 32'(MAX_PULSE);
    localparam logic [31:0] StepCyc   = 32'(STEP);
    localparam logic [31:0] HalfStep  = 32'(STEP / 2);
    localparam logic [31:0] MaxPeriod = 32'(MAX_PERIOD);
    localparam logic [4:0]  MaxIdx    = 5'd18;

    // Synchroniser resets high so a level already high at reset never looks like a rising edge.
    logic [1:0] sync_q;
    logic       pwm_s;
    logic       lvl;
    logic       prev_q;
    logic       rise;
    logic       fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pwm_in};
        end
    end

    assign pwm_s = sync_q[1];

`ifdef PWM_DEGLITCH_EN
    logic [2:0] sh_q;
    logic       filt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= 3'b111;
            filt_q <= 1'b1;
        end else begin
            sh_q   <= {sh_q[1:0], pwm_s};
            filt_q <= lvl;
        end
    end

    // Level moves only once three consecutive samples agree.
    always_comb begin
        lvl = filt_q;
        if (&sh_q) begin
            lvl = 1'b1;
        end else if (~|sh_q) begin
            lvl = 1'b0;
        end
    end
`else
    assign lvl = pwm_s;
`endif

    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

    logic [1:0]  state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] per_q, per_d;
    logic [31:0] wlat_q, wlat_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  idx_q, idx_d;
    logic        oorp_q, oorp_d;
    logic [31:0] width_q, width_d;
    logic [31:0] period_q, period_d;
    logic [4:0]  angle_q, angle_d;
    logic        valid_q, valid_d;
    logic        oor_q, oor_d;
    logic        nosig_q, nosig_d;
    logic [31:0] clamped;
    logic        timeout;

    always_comb begin
        clamped = hi_q;
        if (hi_q < MinPulse) begin
            clamped = MinPulse;
        end else if (hi_q > MaxPulse) begin
            clamped = MaxPulse;
        end
    end

    assign timeout = (state_q != StIdle) && ((hi_q >= MaxPeriod) || (per_q >= MaxPeriod));

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        per_d    = per_q;
        wlat_d   = wlat_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        oorp_d   = oorp_q;
        width_d  = width_q;
        period_d = period_q;
        angle_d  = angle_q;
        valid_d  = 1'b0;
        oor_d    = oor_q;
        nosig_d  = nosig_q;

        if (timeout) begin
            nosig_d = 1'b1;
            state_d = StIdle;
            hi_d    = '0;
            per_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d = StHigh;
                        hi_d    = 32'd1;
                        per_d   = 32'd1;
                    end
                end
                StHigh: begin
                    per_d = per_q + 32'd1;
                    if (fall) begin
                        wlat_d  = hi_q;
                        oorp_d  = (hi_q < MinPulse) || (hi_q > MaxPulse);
                        rem_d   = clamped - MinPulse + HalfStep;
                        idx_d   = '0;
                        state_d = StCalc;
                    end else begin
                        hi_d = hi_q + 32'd1;
                    end
                end
                StCalc: begin
                    if (rise) begin
                        // Next pulse arrived before the index settled: drop this result.
                        oor_d   = 1'b1;
                        state_d = StHigh;
                        hi_d    = 32'd1;
                        per_d   = 32'd1;
                    end else begin
                        per_d = per_q + 32'd1;
                        if ((rem_q >= StepCyc) && (idx_q < MaxIdx)) begin
                            rem_d = rem_q - StepCyc;
                            idx_d = idx_q + 5'd1;
                        end else begin
                            width_d = wlat_q;
                            angle_d = idx_q;
                            oor_d   = oorp_q;
                            valid_d = 1'b1;
                            nosig_d = 1'b0;
                            state_d = StLow;
                        end
                    end
                end
                StLow: begin
                    if (rise) begin
                        period_d = per_q;
                        state_d  = StHigh;
                        hi_d     = 32'd1;
                        per_d    = 32'd1;
                    end else begin
                        per_d = per_q + 32'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= 1'b1;
            state_q  <= StIdle;
            hi_q     <= '0;
            per_q    <= '0;
            wlat_q   <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            oorp_q   <= 1'b0;
            width_q  <= '0;
            period_q <= '0;
            angle_q  <= '0;
            valid_q  <= 1'b0;
            oor_q    <= 1'b0;
            nosig_q  <= 1'b1;
        end else begin
            prev_q   <= lvl;
            state_q  <= state_d;
            hi_q     <= hi_d;
            per_q    <= per_d;
            wlat_q   <= wlat_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            oorp_q   <= oorp_d;
            width_q  <= width_d;
            period_q <= period_d;
            angle_q  <= angle_d;
            valid_q  <= valid_d;
            oor_q    <= oor_d;
            nosig_q  <= nosig_d;
        end
    end

    assign width        = width_q;
    assign period       = period_q;
    assign angle_idx    = angle_q;
    assign valid        = valid_q;
    assign out_of_range = oor_q;
    assign no_signal    = nosig_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with scaled-down timing parameters.
module tb_servo_pwm_decoder;

    localparam int MINP = 500;
    localparam int MAXP = 1000;
    localparam int STP  = 28;
    localparam int MAXT = 6000;
`ifdef PWM_DEGLITCH_EN
    localparam int DGL = 3;
`else
    localparam int DGL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic [31:0] width;
    logic [31:0] period;
    logic [4:0]  angle_idx;
    logic        valid;
    logic        out_of_range;
    logic        no_signal;

    servo_pwm_decoder #(
        .MIN_PULSE (MINP),
        .MAX_PULSE (MAXP),
        .STEP      (STP),
        .MAX_PERIOD(MAXT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .width       (width),
        .period      (period),
        .angle_idx   (angle_idx),
        .valid       (valid),
        .out_of_range(out_of_range),
        .no_signal   (no_signal)
    );

    always #5 clk = ~clk;

    typedef struct { int w; int idx; bit oor; int t; } ev_t;
    typedef struct { int hi; int lo; int ew; int eidx; bit eoor; int edly; } vec_t;

    ev_t  got_q[$];
    vec_t vecs[12];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_period = 0;
    int   last_total = -1;
    int   last_w = 0;
    int   last_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) got_q.push_back('{int'(width), int'(angle_idx), out_of_range, cyc});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference quantiser: nearest 10-degree step of the clamped width, capped at 18.
    function automatic int model_idx(input int w);
        int c;
        int i;
        c = (w < MINP) ? MINP : ((w > MAXP) ? MAXP : w);
        i = (c - MINP + STP / 2) / STP;
        return (i > 18) ? 18 : i;
    endfunction

    task automatic pulse(input int hi, input int lo, input int ew, input int eidx, input bit eoor,
                         input int edly, input string name);
        int fall_cyc;
        got_q.delete();
        if (last_total >= 0) exp_period = last_total;
        pwm_in = 1'b1;
        repeat (hi) tick();
        check({name, " period"}, period, exp_period);
        pwm_in = 1'b0;
        fall_cyc = cyc;
        repeat (lo) tick();
        check({name, " valid count"}, got_q.size(), 1);
        if (got_q.size() >= 1) begin
            check({name, " width"}, got_q[0].w, ew);
            check({name, " angle_idx"}, got_q[0].idx, eidx);
            check({name, " out_of_range"}, got_q[0].oor, eoor);
            check({name, " valid delay"}, got_q[0].t - fall_cyc, edly + DGL);
        end
        check({name, " no_signal"}, no_signal, 0);
        last_total = hi + lo;
        last_w     = ew;
        last_idx   = eidx;
    endtask

    initial begin
        int hi;
        int lo;
        int t0;

        vecs[0]  = '{750, 1250, 750, 9, 1'b0, 13};
        vecs[1]  = '{750, 1250, 750, 9, 1'b0, 13};
        vecs[2]  = '{750, 1250, 750, 9, 1'b0, 13};
        vecs[3]  = '{500, 1500, 500, 0, 1'b0, 4};
        vecs[4]  = '{1000, 1000, 1000, 18, 1'b0, 22};
        vecs[5]  = '{528, 1472, 528, 1, 1'b0, 5};
        vecs[6]  = '{400, 1600, 400, 0, 1'b1, 4};
        vecs[7]  = '{1200, 800, 1200, 18, 1'b1, 22};
        vecs[8]  = '{513, 1487, 513, 0, 1'b0, 4};
        vecs[9]  = '{514, 1486, 514, 1, 1'b0, 5};
        vecs[10] = '{499, 1501, 499, 0, 1'b1, 4};
        vecs[11] = '{1001, 999, 1001, 18, 1'b1, 22};

        repeat (3) tick();
        check("reset width", width, 0);
        check("reset period", period, 0);
        check("reset angle_idx", angle_idx, 0);
        check("reset valid", valid, 0);
        check("reset out_of_range", out_of_range, 0);
        check("reset no_signal", no_signal, 1);
        rst = 1'b0;
        repeat (20) tick();
        check("idle no_signal", no_signal, 1);

        for (int i = 0; i < 12; i++) begin
            pulse(vecs[i].hi, vecs[i].lo, vecs[i].ew, vecs[i].eidx, vecs[i].eoor, vecs[i].edly,
                  $sformatf("vec%0d", i));
        end

        // Rising edge while the index is still being computed.
        got_q.delete();
        if (last_total >= 0) exp_period = last_total;
        pwm_in = 1'b1;
        repeat (1000) tick();
        pwm_in = 1'b0;
        repeat (5) tick();
        pwm_in = 1'b1;
        repeat (20) tick();
        check("abort valid count", got_q.size(), 0);
        check("abort out_of_range", out_of_range, 1);
        check("abort period", period, exp_period);
        check("abort width held", width, last_w);
        repeat (580) tick();
        pwm_in = 1'b0;
        repeat (1000) tick();
        check("post-abort valid count", got_q.size(), 1);
        if (got_q.size() >= 1) begin
            check("post-abort width", got_q[0].w, 600);
            check("post-abort angle_idx", got_q[0].idx, 4);
            check("post-abort out_of_range", got_q[0].oor, 0);
        end
        last_total = 1600;
        last_w = 600;
        last_idx = 4;
        pulse(750, 1250, 750, 9, 1'b0, 13, "post-abort next");

        // 2-cycle low glitch inside a 750-cycle pulse.
        got_q.delete();
        if (last_total >= 0) exp_period = last_total;
        pwm_in = 1'b1;
        repeat (300) tick();
        pwm_in = 1'b0;
        repeat (2) tick();
        pwm_in = 1'b1;
        repeat (448) tick();
        pwm_in = 1'b0;
        repeat (1250) tick();
`ifdef PWM_DEGLITCH_EN
        check("glitch valid count", got_q.size(), 1);
        if (got_q.size() >= 1) begin
            check("glitch width", got_q[0].w, 750);
            check("glitch angle_idx", got_q[0].idx, 9);
            check("glitch out_of_range", got_q[0].oor, 0);
        end
        last_total = 2000;
        last_w = 750;
        last_idx = 9;
`else
        check("glitch valid count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("glitch width a", got_q[0].w, 300);
            check("glitch oor a", got_q[0].oor, 1);
            check("glitch width b", got_q[1].w, 448);
            check("glitch oor b", got_q[1].oor, 1);
            check("glitch angle b", got_q[1].idx, 0);
        end
        check("glitch period", period, 302);
        last_total = 448 + 1250;
        last_w = 448;
        last_idx = 0;
`endif

        for (int i = 0; i < 10; i++) begin
            hi = $urandom_range(1150, 350);
            lo = $urandom_range(1500, 40);
            pulse(hi, lo, hi, model_idx(hi), (hi < MINP) || (hi > MAXP), 4 + model_idx(hi),
                  $sformatf("rnd%0d", i));
        end

        // Input stuck high: timeout in HIGH.
        got_q.delete();
        if (last_total >= 0) exp_period = last_total;
        pwm_in = 1'b1;
        t0 = cyc;
        while (cyc < t0 + MAXT + 2 + DGL) tick();
        check("stuck before timeout no_signal", no_signal, 0);
        tick();
        check("stuck at timeout no_signal", no_signal, 1);
        repeat (500) tick();
        check("stuck valid count", got_q.size(), 0);
        check("stuck width held", width, last_w);
        check("stuck angle held", angle_idx, last_idx);
        check("stuck period held", period, exp_period);
        pwm_in = 1'b0;
        repeat (200) tick();
        last_total = -1;
        pulse(750, 1250, 750, 9, 1'b0, 13, "after timeout 1");
        pulse(528, 1472, 528, 1, 1'b0, 5, "after timeout 2");

        // Input stuck low after a pulse: timeout in LOW.
        pulse(600, 100, 600, 4, 1'b0, 8, "low timeout pulse");
        repeat (MAXT) tick();
        check("low timeout no_signal", no_signal, 1);
        check("low timeout width held", width, 600);
        last_total = -1;

        // Reset asserted during the high phase.
        pulse(750, 1250, 750, 9, 1'b0, 13, "pre-reset");
        got_q.delete();
        pwm_in = 1'b1;
        repeat (200) tick();
        rst = 1'b1;
        #1;
        check("midreset width", width, 0);
        check("midreset period", period, 0);
        check("midreset angle_idx", angle_idx, 0);
        check("midreset no_signal", no_signal, 1);
        repeat (2) tick();
        rst = 1'b0;
        repeat (400) tick();
        pwm_in = 1'b0;
        repeat (100) tick();
        check("partial pulse valid count", got_q.size(), 0);
        check("partial pulse no_signal", no_signal, 1);
        exp_period = 0;
        last_total = -1;
        pulse(1000, 1000, 1000, 18, 1'b0, 22, "post-reset 1");
        pulse(750, 1250, 750, 9, 1'b0, 13, "post-reset 2");
        pulse(750, 1250, 750, 9, 1'b0, 13, "post-reset 3");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
